// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the feeder state encoding.
package uart_pkg;
  typedef enum logic [1:0] {
    FEED_IDLE        = 2'b00,
    FEED_START       = 2'b01,
    FEED_WAIT_ACTIVE = 2'b10,
    FEED_WAIT_DONE   = 2'b11
  } feed_state_t;
  localparam int CLKS_PER_BIT = 434;
  localparam int DEFAULT_TIMEOUT_CLKS = 8192;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: DEPTH x 8 synchronous FIFO with occupancy count, full and empty.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
    end
  end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered byte feeder for a UART transmit engine, one byte outstanding.
// Define UART_TX_FEEDER_TIMEOUT_EN to add the engine-handshake watchdog and tx_timeout.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
`endif
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  output logic            in_ready,
  output logic            tx_data_avail,
  output logic [7:0]      tx_data_byte,
  input  logic            tx_active,
  input  logic            tx_done,
  output logic [ADDR_W:0] fifo_count,
  output logic            busy
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  , output logic          tx_timeout
`endif
);
  feed_state_t state, state_nx;
  logic [7:0] head;
  logic full, empty, expire;
  uart_sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .wr_en(in_valid),
    .wr_data(in_byte),
    .rd_en(tx_data_avail),
    .rd_data(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  assign in_ready = !full;
  assign tx_data_avail = state == FEED_START;
  assign busy = state != FEED_IDLE || !empty;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic [15:0] wd;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      FEED_IDLE:        state_nx = empty ? FEED_IDLE : FEED_START;
      FEED_START:       state_nx = FEED_WAIT_ACTIVE;
      FEED_WAIT_ACTIVE: state_nx = tx_done ? FEED_IDLE : tx_active ? FEED_WAIT_DONE : FEED_WAIT_ACTIVE;
      default:          state_nx = tx_done ? FEED_IDLE : FEED_WAIT_DONE;
    endcase
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // fires on the edge where wd reaches TIMEOUT_CLKS-1 with the engine still silent
    expire = (state inside {FEED_WAIT_ACTIVE, FEED_WAIT_DONE}) && state_nx == state && wd == 16'(TIMEOUT_CLKS - 2);
`else
    expire = 1'b0;
`endif
    if (expire) state_nx = FEED_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FEED_IDLE;
      tx_data_byte <= '0;
    end else begin
      state <= state_nx;
      if (state == FEED_IDLE && !empty) tx_data_byte <= head;
    end
  end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wd <= '0;
      tx_timeout <= 1'b0;
    end else begin
      wd <= (state inside {FEED_WAIT_ACTIVE, FEED_WAIT_DONE}) ? wd + 16'd1 : '0;
      tx_timeout <= tx_timeout || expire;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: feeder bench with a behavioural UART engine and serial-line decoder.
module tb_uart_tx_feeder;
  import uart_pkg::*;
  localparam int DEPTH = 16;
  localparam int CPB = 4;
  logic clock = 1'b0;
  logic reset, in_valid, in_ready, tx_data_avail, tx_active, tx_done, busy, txd;
  logic [7:0] in_byte, tx_data_byte;
  logic [4:0] fifo_count;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic tx_timeout;
`endif
  int checks = 0, errors = 0;
  int eng_mode = 0, pulses = 0, overlap = 0, frame_err = 0;
  logic [9:0] frame;
  logic [7:0] dec_b;
  logic [7:0] got_q[$], ser_q[$], exp_q[$];

  always #5 clock = ~clock;

  uart_tx_feeder #(
    .DEPTH(DEPTH)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    , .TIMEOUT_CLKS(32)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_byte(in_byte),
    .in_ready(in_ready),
    .tx_data_avail(tx_data_avail),
    .tx_data_byte(tx_data_byte),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .fifo_count(fifo_count),
    .busy(busy)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    , .tx_timeout(tx_timeout)
`endif
  );

  // request monitor: a request while the engine is still active or completing is an overlap
  always @(negedge clock)
    if (tx_data_avail === 1'b1) begin
      pulses++;
      if (tx_active || tx_done) overlap++;
    end

  // engine model: mode 0 normal, 1 stall with tx_active high, 2 never responds
  initial begin
    tx_active = 0;
    tx_done = 0;
    txd = 1;
    forever begin
      @(negedge clock);
      if (tx_data_avail === 1'b1 && eng_mode != 2) begin
        frame = {1'b1, tx_data_byte, 1'b0};
        got_q.push_back(tx_data_byte);
        @(negedge clock);
        tx_active = 1;
        while (eng_mode == 1) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
          txd = frame[i];
          repeat (CPB) @(negedge clock);
        end
        tx_active = 0;
        tx_done = 1;
        @(negedge clock);
        tx_done = 0;
      end
    end
  end

  // serial decoder samples mid-bit
  initial forever begin
    @(posedge clock);
    if (txd === 1'b0) begin
      repeat (CPB / 2) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clock);
        dec_b[i] = txd;
      end
      repeat (CPB) @(posedge clock);
      if (txd !== 1'b1) frame_err++;
      ser_q.push_back(dec_b);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    ok = 0;
    while (n < 4000 && !ok) begin
      tick(1);
      n++;
      ok = !busy && !tx_active && !tx_done;
    end
    tick(4);
  endtask

  task automatic test_reset;
    reset = 1;
    in_valid = 0;
    in_byte = 0;
    tick(2);
    reset = 0;
    tick(5);
    checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b expected 0", tx_data_avail); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (tx_data_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", tx_data_byte); end
  endtask

  task automatic test_single(input logic [7:0] b);
    int p0 = pulses;
    bit ok = 0;
    got_q.delete();
    ser_q.delete();
    in_valid = 1;
    in_byte = b;
    tick(1);
    in_valid = 0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    checks++; if (tx_data_avail !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", tx_data_avail); end
    tick(1);
    checks++; if (tx_data_avail !== 1'b1) begin errors++; $display("FAIL single_avail: got %b expected 1", tx_data_avail); end
    checks++; if (tx_data_byte !== b) begin errors++; $display("FAIL single_byte: got %h expected %h", tx_data_byte, b); end
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      ok = tx_done;
    end
    checks++; if (!ok) begin errors++; $display("FAIL single_done_wait: got no tx_done expected tx_done within 200 cycles"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done: got %b expected 1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    tick(4);
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulses - p0); end
    checks++; if (got_q.size() != 1 || got_q[0] !== b) begin errors++; $display("FAIL single_engine_byte: got size %0d expected %h", got_q.size(), b); end
    checks++; if (ser_q.size() != 1 || ser_q[0] !== b || frame_err != 0) begin errors++; $display("FAIL single_serial: got size %0d framing errors %0d expected %h", ser_q.size(), frame_err, b); end
    checks++; if (tx_data_byte !== b) begin errors++; $display("FAIL single_hold: got %h expected %h", tx_data_byte, b); end
  endtask

  task automatic test_burst;
    int p0 = pulses;
    int bad = 0;
    bit ok;
    got_q.delete();
    ser_q.delete();
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1;
      in_byte = 8'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready: got %b expected 1 at write %0d", in_ready, i); end
      tick(1);
    end
    in_valid = 0;
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_drain: got busy expected idle"); end
    checks++; if (pulses - p0 != 16) begin errors++; $display("FAIL burst_pulses: got %0d expected 16", pulses - p0); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL burst_overlap: got %0d expected 0", overlap); end
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL burst_count: got %0d expected 16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 8'(i + 1)) bad++;
    for (int i = 0; i < ser_q.size(); i++) if (ser_q[i] !== 8'(i + 1)) bad++;
    checks++; if (bad != 0 || ser_q.size() != 16) begin errors++; $display("FAIL burst_order: got %0d wrong bytes, %0d serial frames expected 0 and 16", bad, ser_q.size()); end
  endtask

  task automatic test_full;
    int bad = 0;
    bit ok;
    got_q.delete();
    ser_q.delete();
    exp_q.delete();
    eng_mode = 1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1;
      in_byte = 8'($urandom);
      exp_q.push_back(in_byte);
      if (in_ready !== 1'b1) bad++;
      tick(1);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_ready_fill: got %0d refusals expected 0", bad); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", in_ready); end
    in_byte = 8'($urandom);
    tick(3);
    checks++; if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin errors++; $display("FAIL full_ignore: got count %0d ready %b expected 16 and 0", fifo_count, in_ready); end
    in_valid = 0;
    eng_mode = 0;
    drain(ok);
    checks++; if (!ok || got_q.size() != 17) begin errors++; $display("FAIL full_drain: got %0d bytes expected 17", got_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < 17; i++) if (got_q[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_order: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    int p0;
    bit ok = 0;
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_byte = 8'($urandom);
      tick(1);
    end
    in_valid = 0;
    for (int i = 0; i < 50 && !tx_active; i++) tick(1);
    tick(2);
    checks++; if (fifo_count !== 5'd5 || busy !== 1'b1) begin errors++; $display("FAIL mid_queued: got count %0d busy %b expected 5 and 1", fifo_count, busy); end
    reset = 1;
    tick(1);
    reset = 0;
    p0 = pulses;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    checks++; if (busy !== 1'b0 || tx_data_avail !== 1'b0) begin errors++; $display("FAIL mid_idle: got busy %b avail %b expected 0 0", busy, tx_data_avail); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      ok = tx_done;
    end
    tick(5);
    checks++; if (!ok) begin errors++; $display("FAIL mid_stray_wait: got no tx_done expected stray tx_done"); end
    checks++; if (pulses != p0 || busy !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL mid_stray: got %0d pulses busy %b count %0d expected 0 0 0", pulses - p0, busy, fifo_count); end
    got_q.delete();
    ser_q.delete();
  endtask

  task automatic test_random;
    int n, bad = 0;
    bit ok;
    got_q.delete();
    ser_q.delete();
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      tick($urandom_range(0, 3));
      in_valid = 1;
      in_byte = 8'($urandom);
      n = 0;
      while (!in_ready && n < 500) begin
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL rand_refuse: got count %0d expected %0d", fifo_count, DEPTH); end
        tick(1);
        n++;
      end
      checks++; if (n >= 500 || fifo_count >= 5'(DEPTH)) begin errors++; $display("FAIL rand_accept: got count %0d after %0d waits expected below %0d", fifo_count, n, DEPTH); end
      exp_q.push_back(in_byte);
      tick(1);
      in_valid = 0;
    end
    drain(ok);
    checks++; if (!ok || got_q.size() != exp_q.size() || ser_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_size: got %0d/%0d expected %0d", got_q.size(), ser_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
      if (i < ser_q.size() && ser_q[i] !== exp_q[i]) bad++;
    end
    checks++; if (bad != 0 || frame_err != 0 || overlap != 0) begin errors++; $display("FAIL rand_data: got %0d wrong, %0d framing, %0d overlaps expected 0", bad, frame_err, overlap); end
  endtask

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  task automatic test_timeout;
    logic [7:0] b1, b2;
    int n = 0;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    eng_mode = 2;
    in_valid = 1;
    in_byte = b1;
    tick(1);
    in_byte = b2;
    tick(1);
    in_valid = 0;
    while (!tx_data_avail && n < 10) begin tick(1); n++; end
    checks++; if (tx_data_byte !== b1) begin errors++; $display("FAIL to_first: got %h expected %h", tx_data_byte, b1); end
    n = 0;
    while (!tx_timeout && n < 100) begin tick(1); n++; end
    checks++; if (n != 32) begin errors++; $display("FAIL to_delay: got %0d expected 32", n); end
    tick(1);
    checks++; if (tx_data_avail !== 1'b1 || tx_data_byte !== b2) begin errors++; $display("FAIL to_next: got avail %b byte %h expected 1 %h", tx_data_avail, tx_data_byte, b2); end
    checks++; if (tx_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", tx_timeout); end
    tick(40);
    eng_mode = 0;
    reset = 1;
    tick(1);
    reset = 0;
    checks++; if (tx_timeout !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", tx_timeout); end
  endtask
`endif

  initial begin
    reset = 1;
    in_valid = 0;
    in_byte = 0;
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_burst();
    test_full();
    test_reset_mid();
    test_random();
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
